// File: rtl/gpu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_sched_pkg
// Description : Shared types for the GPU command scheduler: the packed
//               command record carried through the queue and the issue
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_sched_pkg;

    localparam int c_OPCODE_W = 5;

    // One complete GPU command: opcode plus every operand (87 bits).
    typedef struct packed {
        logic [c_OPCODE_W-1:0] instruction;
        logic [15:0]           cpu_data;
        logic [15:0]           int_to_fp;
        logic [12:0]           gpc_val_s;
        logic [12:0]           gpc_val_i;
        logic [7:0]            inc_a;
        logic [7:0]            inc_b;
        logic [7:0]            repeat_amt;
    } gpu_cmd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2
    } sched_state_e;

endpackage : gpu_sched_pkg
`default_nettype wire

// File: rtl/gpu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gpu_cmd_fifo
// Description : Synchronous FIFO of complete GPU commands. Head is read
//               combinationally; flush empties the queue and overrides any
//               push or pop on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_cmd_fifo
    import gpu_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  gpu_cmd_t        din,
    output gpu_cmd_t        dout,
    output logic            full,
    output logic            empty,
    output logic [CNTW-1:0] count
);

    localparam int c_AW = $clog2(DEPTH);

    gpu_cmd_t        mem_q [DEPTH];
    logic [c_AW-1:0] wr_ptr_q;
    logic [c_AW-1:0] rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic            w_push;
    logic            w_pop;

    // Full/empty come only from the registered count, so a pop cannot make
    // room for a push on the same edge.
    assign full   = (count_q == CNTW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign dout   = mem_q[rd_ptr_q];
    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    // Storage array; only written on an accepted push, never overwritten when full.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= din;
    end

endmodule : gpu_cmd_fifo
`default_nettype wire

// File: rtl/gpu_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gpu_cmd_scheduler
// Description : Buffers complete GPU commands and issues them one at a time
//               to GPU16, holding gpu_start until accepted and then waiting
//               for the GPU to go busy (or a timeout) before the next issue.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_cmd_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int CNTW        = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [c_OPCODE_W-1:0] cmd_instruction,
    input  logic [15:0]           cmd_data,
    input  logic [15:0]           cmd_int,
    input  logic [12:0]           cmd_gpc_s,
    input  logic [12:0]           cmd_gpc_i,
    input  logic [7:0]            cmd_inc_a,
    input  logic [7:0]            cmd_inc_b,
    input  logic [7:0]            cmd_repeat,
    input  logic                  flush,
    input  logic                  gpu_busy,
    output logic                  gpu_start,
    output logic [c_OPCODE_W-1:0] instruction,
    output logic [15:0]           cpu_data,
    output logic [15:0]           int_to_fp,
    output logic [12:0]           gpc_val_s,
    output logic [12:0]           gpc_val_i,
    output logic [7:0]            gpc_inc_amount_a,
    output logic [7:0]            gpc_inc_amount_b,
    output logic [7:0]            repeat_op_amount,
    output logic [CNTW-1:0]       queue_count,
    output logic                  idle,
    output logic [15:0]           issued_count
);

    localparam int c_TW = $clog2(ACK_TIMEOUT) + 1;

    gpu_cmd_t        w_din;
    gpu_cmd_t        w_dout;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [CNTW-1:0] w_count;

    sched_state_e    state_q;
    logic            start_q;
    gpu_cmd_t        cmd_q;
    logic [c_TW-1:0] tmo_q;
    logic [15:0]     issued_q;

    assign w_din = {cmd_instruction, cmd_data, cmd_int, cmd_gpc_s, cmd_gpc_i,
                    cmd_inc_a, cmd_inc_b, cmd_repeat};

    // Flush blocks the pop so nothing leaves the queue on a discard edge.
    assign w_pop = (state_q == IDLE) && !w_empty && !flush;

    gpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .pop   (w_pop),
        .flush (flush),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Issue sequencer: pop -> hold until accepted -> wait for GPU to go busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            cmd_q    <= '0;
            tmo_q    <= '0;
            issued_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_pop) begin
                        cmd_q   <= w_dout;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An accept on a flush edge still counts as issued.
                    if (!gpu_busy) begin
                        start_q  <= 1'b0;
                        issued_q <= issued_q + 16'd1;
                        tmo_q    <= '0;
                        state_q  <= WAIT_BUSY;
                    end else if (flush) begin
                        start_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WAIT_BUSY: begin
                    // Short commands may finish without busy ever being seen.
                    if (gpu_busy || (tmo_q == c_TW'(ACK_TIMEOUT - 1))) begin
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready        = ~w_full;
    assign queue_count      = w_count;
    assign idle             = w_empty && (state_q == IDLE) && !gpu_busy;
    assign issued_count     = issued_q;
    assign gpu_start        = start_q;
    assign instruction      = cmd_q.instruction;
    assign cpu_data         = cmd_q.cpu_data;
    assign int_to_fp        = cmd_q.int_to_fp;
    assign gpc_val_s        = cmd_q.gpc_val_s;
    assign gpc_val_i        = cmd_q.gpc_val_i;
    assign gpc_inc_amount_a = cmd_q.inc_a;
    assign gpc_inc_amount_b = cmd_q.inc_b;
    assign repeat_op_amount = cmd_q.repeat_amt;

endmodule : gpu_cmd_scheduler
`default_nettype wire

// File: tb/tb_gpu_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_cmd_scheduler
// Description : Self-checking bench for gpu_cmd_scheduler. A queue-based
//               model predicts every output each cycle; directed scenarios
//               add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_cmd_scheduler;
    import gpu_sched_pkg::*;

    localparam int DEPTH    = 8;
    localparam int CNTW     = 4;
    localparam int ACK      = 4;
    localparam int BUSY_LEN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    gpu_cmd_t        cmd_in;
    logic            flush;
    logic            gpu_busy;
    logic            gpu_start;
    logic [4:0]      instruction;
    logic [15:0]     cpu_data;
    logic [15:0]     int_to_fp;
    logic [12:0]     gpc_val_s;
    logic [12:0]     gpc_val_i;
    logic [7:0]      gpc_inc_amount_a;
    logic [7:0]      gpc_inc_amount_b;
    logic [7:0]      repeat_op_amount;
    logic [CNTW-1:0] queue_count;
    logic            idle;
    logic [15:0]     issued_count;
    gpu_cmd_t        dut_ops;

    gpu_cmd_scheduler #(.DEPTH(DEPTH), .CNTW(CNTW), .ACK_TIMEOUT(ACK)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_instruction  (cmd_in.instruction),
        .cmd_data         (cmd_in.cpu_data),
        .cmd_int          (cmd_in.int_to_fp),
        .cmd_gpc_s        (cmd_in.gpc_val_s),
        .cmd_gpc_i        (cmd_in.gpc_val_i),
        .cmd_inc_a        (cmd_in.inc_a),
        .cmd_inc_b        (cmd_in.inc_b),
        .cmd_repeat       (cmd_in.repeat_amt),
        .flush            (flush),
        .gpu_busy         (gpu_busy),
        .gpu_start        (gpu_start),
        .instruction      (instruction),
        .cpu_data         (cpu_data),
        .int_to_fp        (int_to_fp),
        .gpc_val_s        (gpc_val_s),
        .gpc_val_i        (gpc_val_i),
        .gpc_inc_amount_a (gpc_inc_amount_a),
        .gpc_inc_amount_b (gpc_inc_amount_b),
        .repeat_op_amount (repeat_op_amount),
        .queue_count      (queue_count),
        .idle             (idle),
        .issued_count     (issued_count)
    );

    assign dut_ops = {instruction, cpu_data, int_to_fp, gpc_val_s, gpc_val_i,
                      gpc_inc_amount_a, gpc_inc_amount_b, repeat_op_amount};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    gpu_cmd_t    mq[$];        // commands waiting in the queue
    gpu_cmd_t    m_cur;        // command on the GPU operand bus
    bit          m_hold;       // a command is being offered to the GPU
    int          m_wait;       // cycles since last accept, -1 when not waiting
    logic [15:0] m_issued;
    bit          m_valid = 1'b0;
    bit          m_acc_evt = 1'b0;
    int          cyc = 0;

    initial begin
        bit was_full, was_empty, do_pop, do_push;
        forever begin
            @(posedge clk);
            cyc++;
            m_acc_evt = 1'b0;
            if (reset) begin
                mq.delete();
                m_cur    = '0;
                m_hold   = 1'b0;
                m_wait   = -1;
                m_issued = '0;
                m_valid  = 1'b1;
            end else if (m_valid) begin
                was_full  = (mq.size() == DEPTH);
                was_empty = (mq.size() == 0);
                do_push   = cmd_valid && !was_full;
                do_pop    = 1'b0;
                if (m_hold) begin
                    if (!gpu_busy) begin
                        m_hold    = 1'b0;
                        m_issued  = m_issued + 16'd1;
                        m_wait    = 0;
                        m_acc_evt = 1'b1;
                    end else if (flush) begin
                        m_hold = 1'b0;
                    end
                end else if (m_wait >= 0) begin
                    if (gpu_busy || m_wait == ACK - 1) m_wait = -1;
                    else m_wait++;
                end else begin
                    do_pop = !was_empty && !flush;
                end
                if (flush) begin
                    mq.delete();
                end else begin
                    if (do_pop) begin
                        m_cur  = mq.pop_front();
                        m_hold = 1'b1;
                    end
                    if (do_push) mq.push_back(cmd_in);
                end
            end
        end
    end

    // ---------------- GPU responder ----------------
    bit gmode = 1'b1;   // 1: raise busy for BUSY_LEN cycles after each accept
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gmode) begin
                if (m_acc_evt) cnt = BUSY_LEN;
                if (cnt > 0) begin
                    gpu_busy = 1'b1;
                    cnt--;
                end else begin
                    gpu_busy = 1'b0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int              last_acc = -1;
    int              spacing_last = 0;
    logic            prev_start = 1'b0;
    logic [CNTW-1:0] prev_qc = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("gpu_start", 128'(gpu_start), 128'(m_hold));
                chk("operands", 128'(dut_ops), 128'(m_cur));
                chk("queue_count", 128'(queue_count), 128'(mq.size()));
                chk("cmd_ready", 128'(cmd_ready), 128'(mq.size() < DEPTH));
                chk("issued_count", 128'(issued_count), 128'(m_issued));
                chk("idle", 128'(idle),
                    128'(mq.size() == 0 && !m_hold && m_wait < 0 && !gpu_busy));
                if (gpu_start && !prev_start)
                    chk("pop_nonempty", 128'(prev_qc != '0), 128'(1));
                if (gpu_start && !gpu_busy) begin
                    if (last_acc >= 0) begin
                        spacing_last = cyc - last_acc;
                        chk("accept_spacing_ge3", 128'(spacing_last >= 3), 128'(1));
                    end
                    last_acc = cyc;
                end
                prev_start = gpu_start;
                prev_qc    = queue_count;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_cmd(input gpu_cmd_t c);
        cmd_in    = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issued(input logic [15:0] n, input int budget);
        int k;
        k = 0;
        while (issued_count != n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_issued", 128'(issued_count), 128'(n));
    endtask

    function automatic gpu_cmd_t mk(input int i, input logic [4:0] op);
        gpu_cmd_t c;
        c.instruction = op;
        c.cpu_data    = 16'hA000 + 16'(i);
        c.int_to_fp   = 16'(i * 3);
        c.gpc_val_s   = 13'(100 + i);
        c.gpc_val_i   = 13'(200 + i);
        c.inc_a       = 8'(i);
        c.inc_b       = 8'(i + 1);
        c.repeat_amt  = 8'(i + 2);
        return c;
    endfunction

    initial begin
        gpu_cmd_t c;
        reset = 1'b1; cmd_valid = 1'b0; flush = 1'b0; gpu_busy = 1'b0; cmd_in = '0;
        gmode = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_gpu_start", 128'(gpu_start), 128'(0));
        chk("rst_queue_count", 128'(queue_count), 128'(0));
        chk("rst_issued", 128'(issued_count), 128'(0));
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_idle", 128'(idle), 128'(1));

        // 1: single command, responsive GPU
        c = '0; c.instruction = 5'h03; c.cpu_data = 16'h1234; c.repeat_amt = 8'd2;
        push_cmd(c);
        chk("t1_qc_after_push", 128'(queue_count), 128'(1));
        chk("t1_start_not_yet", 128'(gpu_start), 128'(0));
        tick();
        chk("t1_start", 128'(gpu_start), 128'(1));
        chk("t1_opcode", 128'(instruction), 128'(5'h03));
        chk("t1_data", 128'(cpu_data), 128'(16'h1234));
        chk("t1_repeat", 128'(repeat_op_amount), 128'(8'd2));
        tick();
        chk("t1_start_dropped", 128'(gpu_start), 128'(0));
        chk("t1_issued", 128'(issued_count), 128'(1));
        chk("t1_opcode_held", 128'(instruction), 128'(5'h03));
        repeat (5) tick();
        chk("t1_idle", 128'(idle), 128'(1));

        // 2: fill while GPU busy, then drain in order
        gmode = 1'b0; gpu_busy = 1'b1;
        for (int i = 0; i < 9; i++) push_cmd(mk(i, 5'(8 + i)));
        chk("t2_ready_full", 128'(cmd_ready), 128'(0));
        chk("t2_qc_full", 128'(queue_count), 128'(8));
        chk("t2_start_held", 128'(gpu_start), 128'(1));
        chk("t2_head_opcode", 128'(instruction), 128'(5'h08));
        cmd_in = mk(99, 5'h1F); cmd_valid = 1'b1;
        tick(); tick();
        cmd_valid = 1'b0;
        chk("t2_no_push_when_full", 128'(queue_count), 128'(8));
        gmode = 1'b1;
        wait_issued(16'd10, 200);
        chk("t2_last_opcode", 128'(instruction), 128'(5'h10));
        chk("t2_last_data", 128'(cpu_data), 128'(16'hA008));
        repeat (8) tick();

        // 3: GPU never raises busy -> timeout path
        gmode = 1'b0; gpu_busy = 1'b0;
        push_cmd(mk(20, 5'h15));
        push_cmd(mk(21, 5'h16));
        wait_issued(16'd12, 50);
        chk("t3_timeout_spacing", 128'(spacing_last), 128'(6));
        repeat (6) tick();

        // 4: flush while holding with three queued
        gpu_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(mk(30 + i, 5'(1 + i)));
        chk("t4_qc", 128'(queue_count), 128'(3));
        chk("t4_start", 128'(gpu_start), 128'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_start_cleared", 128'(gpu_start), 128'(0));
        chk("t4_qc_zero", 128'(queue_count), 128'(0));
        chk("t4_issued_same", 128'(issued_count), 128'(12));
        repeat (2) tick();

        // 5: flush on the accept edge, plus a push that must be discarded
        push_cmd(mk(40, 5'h0A));
        push_cmd(mk(41, 5'h0B));
        chk("t5_start", 128'(gpu_start), 128'(1));
        chk("t5_qc", 128'(queue_count), 128'(1));
        gpu_busy = 1'b0; flush = 1'b1;
        cmd_in = mk(42, 5'h0C); cmd_valid = 1'b1;
        tick();
        flush = 1'b0; cmd_valid = 1'b0;
        chk("t5_issued", 128'(issued_count), 128'(13));
        chk("t5_qc_zero", 128'(queue_count), 128'(0));
        chk("t5_start_low", 128'(gpu_start), 128'(0));
        repeat (6) tick();
        chk("t5_idle", 128'(idle), 128'(1));

        // 6: reset while waiting with two queued
        for (int i = 0; i < 3; i++) push_cmd(mk(50 + i, 5'(5'h11 + i)));
        chk("t6_qc", 128'(queue_count), 128'(2));
        chk("t6_issued", 128'(issued_count), 128'(14));
        chk("t6_start_low", 128'(gpu_start), 128'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_start", 128'(gpu_start), 128'(0));
        chk("t6_rst_ops", 128'(dut_ops), 128'(0));
        chk("t6_rst_issued", 128'(issued_count), 128'(0));
        chk("t6_rst_qc", 128'(queue_count), 128'(0));
        chk("t6_rst_ready", 128'(cmd_ready), 128'(1));
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_gpu_cmd_scheduler
`default_nettype wire
